// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation controller: state encoding and width defaults.
package modexp_pkg;

  localparam int N_DEF      = 512;
  localparam int E_BITS_DEF = 512;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] PRE    = 4'd1;
  localparam logic [3:0] PRE_W  = 4'd2;
  localparam logic [3:0] SQ     = 4'd3;
  localparam logic [3:0] SQ_W   = 4'd4;
  localparam logic [3:0] MUL    = 4'd5;
  localparam logic [3:0] MUL_W  = 4'd6;
  localparam logic [3:0] POST   = 4'd7;
  localparam logic [3:0] POST_W = 4'd8;
  localparam logic [3:0] FIN    = 4'd9;
  localparam logic [3:0] SKIP   = 4'd10;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving a Montgomery multiplier (x^e mod m).
// Optional macro MODEXP_SKIP_LEADING_ZEROS_EN skips exponent bits above the leading one.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int E_BITS = E_BITS_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N-1:0]      in_x,
  input  logic [E_BITS-1:0] in_e,
  input  logic [N-1:0]      in_m,
  input  logic [N-1:0]      in_r_mod,
  input  logic [N-1:0]      in_r2_mod,
  output logic [N-1:0]      result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [N-1:0]      mm_a,
  output logic [N-1:0]      mm_b,
  output logic [N-1:0]      mm_m,
  input  logic [N-1:0]      mm_result,
  input  logic              mm_done,
  output logic [3:0]        state_dbg
);

  // Multiplier handshake: operands are registered in an issue state and appear together
  // with the one-cycle mm_start pulse; they stay frozen until mm_done, which is honoured
  // only in the matching wait state.

  localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(E_BITS - 1);

  logic [3:0]        state, state_nxt;
  logic [N-1:0]      x_q, r2_q, xt, acc;
  logic [E_BITS-1:0] e_q;
  logic [IW-1:0]     idx;
  logic              idx_dec;
  logic              idx_last;
  logic              cur_bit;

  assign idx_last = (idx == '0);
  assign cur_bit  = e_q[idx];

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_dec   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = PRE;
      PRE:   state_nxt = PRE_W;
      PRE_W: begin
        if (mm_done) begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          state_nxt = (e_q == '0) ? POST : SKIP;
`else
          state_nxt = SQ;
`endif
        end
      end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      // Squaring R mod m is the identity, so leading zero bits cost one cycle each and no multiply.
      SKIP: begin
        if (cur_bit)       state_nxt = SQ;
        else if (idx_last) state_nxt = POST;
        else               idx_dec   = 1'b1;
      end
`endif
      SQ:    state_nxt = SQ_W;
      SQ_W: begin
        if (mm_done) begin
          if (cur_bit)       state_nxt = MUL;
          else if (idx_last) state_nxt = POST;
          else begin
            state_nxt = SQ;
            idx_dec   = 1'b1;
          end
        end
      end
      MUL:   state_nxt = MUL_W;
      MUL_W: begin
        if (mm_done) begin
          if (idx_last) state_nxt = POST;
          else begin
            state_nxt = SQ;
            idx_dec   = 1'b1;
          end
        end
      end
      POST:   state_nxt = POST_W;
      POST_W: if (mm_done) state_nxt = FIN;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done      = (state == FIN);
    busy      = (state != IDLE) && (state != FIN);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q      <= '0;
      e_q      <= '0;
      r2_q     <= '0;
      xt       <= '0;
      acc      <= '0;
      idx      <= IDX_TOP;
      result   <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
    end else begin
      mm_start <= (state == PRE) || (state == SQ) || (state == MUL) || (state == POST);
      case (state)
        IDLE: begin
          if (start) begin
            x_q  <= in_x;
            e_q  <= in_e;
            mm_m <= in_m;
            acc  <= in_r_mod;
            r2_q <= in_r2_mod;
            idx  <= IDX_TOP;
          end
        end
        PRE: begin
          mm_a <= x_q;
          mm_b <= r2_q;
        end
        PRE_W: if (mm_done) xt <= mm_result;
        SQ: begin
          mm_a <= acc;
          mm_b <= acc;
        end
        SQ_W:  if (mm_done) acc <= mm_result;
        MUL: begin
          mm_a <= acc;
          mm_b <= xt;
        end
        MUL_W: if (mm_done) acc <= mm_result;
        // Multiplying by plain 1 strips the Montgomery factor R from the accumulator.
        POST: begin
          mm_a <= acc;
          mm_b <= N'(1);
        end
        POST_W: if (mm_done) result <= mm_result;
        default: ;
      endcase
      if (idx_dec) idx <= idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl at N=E_BITS=16 with a behavioural 5-cycle Montgomery multiplier.
module tb_modexp_ctrl;
  import modexp_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_e = '0, in_m = '0, in_r_mod = '0, in_r2_mod = '0;
  logic [W-1:0]  result, mm_a, mm_b, mm_m;
  logic [W-1:0]  mm_result = '0;
  logic          mm_done = 1'b0;
  logic          done, busy, mm_start;
  logic [3:0]    state_dbg;

  int n_vec = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  modexp_ctrl #(.N(W), .E_BITS(W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r_mod(in_r_mod), .in_r2_mod(in_r2_mod),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    logic [63:0] r;
    r = 64'd1 % m;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * x) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic int exp_mults(input logic [W-1:0] e);
    int pop;
    int msb;
    pop = 0;
    msb = -1;
    for (int i = 0; i < W; i++) if (e[i]) begin pop++; msb = i; end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    if (e == '0) return 2;
    return 2 + msb + 1 + pop;
`else
    return 2 + W + pop;
`endif
  endfunction

  // Behavioural multiplier: captures operands on mm_start, answers after a fixed latency.
  logic [W-1:0] mm_res_p;
  logic         mm_pend = 1'b0;
  int           mm_wait = 0;
  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (!resetn) begin
      mm_pend <= 1'b0;
      mm_wait <= 0;
    end else if (mm_start) begin
      mm_res_p <= mont(mm_a, mm_b, mm_m);
      mm_pend  <= 1'b1;
      mm_wait  <= 3;
    end else if (mm_pend) begin
      if (mm_wait == 0) begin
        mm_done   <= 1'b1;
        mm_result <= mm_res_p;
        mm_pend   <= 1'b0;
      end else begin
        mm_wait <= mm_wait - 1;
      end
    end
  end

  int cyc = 0, mm_cnt = 0, done_cnt = 0, last_mm = 0, done_lat = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mm_start) mm_cnt++;
    if (mm_done) last_mm = cyc;
    if (done) begin
      done_cnt++;
      done_lat = cyc - last_mm;
    end
  end

  task automatic set_operands(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] m);
    logic [63:0] r1, r2;
    r1 = (64'd1 << W) % m;
    r2 = (64'd1 << (2 * W)) % m;
    in_x = x;
    in_e = e;
    in_m = m;
    in_r_mod = r1[W-1:0];
    in_r2_mod = r2[W-1:0];
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: done not seen within 5000 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] e,
                        input logic [W-1:0] m);
    int m0, d0, nm;
    bit ok;
    logic [W-1:0] got;
    @(posedge clk); #1;
    set_operands(x, e, m);
    start = 1'b1;
    exp_q.push_back(ref_pow(x, e, m));
    nm = exp_mults(e);
    m0 = mm_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    set_operands(16'h0003, 16'h5555, 16'h0007);
    n_vec++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b want 1", name, busy); end
    wait_done(name, ok);
    got = exp_q.pop_front();
    if (ok) begin
      n_vec++;
      if (result !== got) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", name, result, got);
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt - d0);
    end
    n_vec++;
    if (mm_cnt - m0 != nm) begin
      n_fail++; $display("FAIL %s mm_starts: got %0d want %0d", name, mm_cnt - m0, nm);
    end
    n_vec++;
    if (done_lat != 1) begin
      n_fail++; $display("FAIL %s done_latency: got %0d want 1", name, done_lat);
    end
    n_vec++;
    if (result !== got || busy !== 1'b0 || mm_m !== m) begin
      n_fail++;
      $display("FAIL %s hold: result %h busy %b mm_m %h want %h 0 %h", name, result, busy, mm_m, got, m);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (state_dbg !== IDLE || done !== 1'b0 || busy !== 1'b0 || mm_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: state %0d done %b busy %b mm_start %b want 0 0 0 0",
               state_dbg, done, busy, mm_start);
    end
    n_vec++;
    if (result !== '0 || mm_a !== '0 || mm_b !== '0 || mm_m !== '0) begin
      n_fail++;
      $display("FAIL reset_data: result %h mm_a %h mm_b %h mm_m %h want all 0", result, mm_a, mm_b, mm_m);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    run_op("x5_e3", 16'd5, 16'd3, 16'd13);
    n_vec++;
    if (result !== 16'd8) begin n_fail++; $display("FAIL x5_e3_const: got %0d want 8", result); end
  endtask

  task automatic test_boundary();
    run_op("e0", 16'd12, 16'd0, 16'd13);
    n_vec++;
    if (result !== 16'd1) begin n_fail++; $display("FAIL e0_const: got %0d want 1", result); end
    run_op("e1", 16'd7, 16'd1, 16'd13);
    n_vec++;
    if (result !== 16'd7) begin n_fail++; $display("FAIL e1_const: got %0d want 7", result); end
    run_op("all_ones", 16'hBEEF, 16'hFFFF, 16'hFFF1);
  endtask

  task automatic test_start_glitch();
    int d0;
    bit ok;
    logic [W-1:0] got;
    d0 = done_cnt;
    @(posedge clk); #1;
    set_operands(16'd5, 16'd3, 16'd13);
    start = 1'b1;
    exp_q.push_back(16'd8);
    @(posedge clk); #1;
    set_operands(16'd7, 16'd1, 16'd11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    set_operands(16'd12, 16'd0, 16'd13);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("glitch", ok);
    got = exp_q.pop_front();
    if (ok) begin
      n_vec++;
      if (result !== got) begin n_fail++; $display("FAIL glitch result: got %h want %h", result, got); end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch single_op: dones %0d busy %b want 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit hit;
    hit = 1'b0;
    @(posedge clk); #1;
    set_operands(16'd9, 16'hA5A5, 16'd101);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (state_dbg == SQ_W) begin hit = 1'b1; break; end
    end
    n_vec++;
    if (!hit) begin n_fail++; $display("FAIL reset_mid reach_sq_w: state %0d want %0d", state_dbg, SQ_W); end
    d0 = done_cnt;
    resetn = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || mm_start !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid abort: busy %b mm_start %b state %0d want 0 0 0", busy, mm_start, state_dbg);
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    n_vec++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL reset_mid no_done: got %0d dones want 0", done_cnt - d0); end
    run_op("after_reset", 16'd5, 16'd3, 16'd13);
  endtask

  task automatic test_random();
    logic [W-1:0] m, x, e;
    for (int k = 0; k < 4; k++) begin
      m = W'($urandom_range(3, 16'hFFFF)) | 16'h0001;
      x = W'($urandom_range(0, int'(m) - 1));
      e = W'($urandom_range(0, 16'hFFFF));
      run_op("random", x, e, m);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_start_glitch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
